// File: rtl/eth_rxmii_deframer_if.sv
// Bundles the PHY-side MII receive signals, frame limits and the byte/status
// outputs of eth_rxmii_deframer. The master side drives the PHY stream; the deframer is the slave.
interface eth_rxmii_deframer_if;
  logic        MRxDV;
  logic [3:0]  MRxD;
  logic        MRxErr;
  logic [15:0] MinFL;
  logic [15:0] MaxFL;
  logic        HugEn;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxStartFrm;
  logic        RxEndFrm;
  logic [15:0] ByteCnt;
  logic        CrcError;
  logic        LengthError;
  logic        DribbleNibble;
  logic        RxErrSeen;
  logic        Busy;

  modport master (
    output MRxDV, MRxD, MRxErr, MinFL, MaxFL, HugEn,
    input  RxData, RxValid, RxStartFrm, RxEndFrm, ByteCnt,
           CrcError, LengthError, DribbleNibble, RxErrSeen, Busy
  );

  modport slave (
    input  MRxDV, MRxD, MRxErr, MinFL, MaxFL, HugEn,
    output RxData, RxValid, RxStartFrm, RxEndFrm, ByteCnt,
           CrcError, LengthError, DribbleNibble, RxErrSeen, Busy
  );
endinterface

// File: rtl/eth_rxmii_deframer.sv
// Receive MII deframer: strips preamble/SFD, assembles bytes, reports per-frame status.
// Define ETH_RX_CRC_CHECK_EN to build the FCS checker; otherwise CrcError is tied low.
module eth_rxmii_deframer #(
  parameter int unsigned MIN_PRE_NIB = 2,
  parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
  input logic MRxClk,
  input logic Reset,
  eth_rxmii_deframer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA_LO, DATA_HI, DROP} state_t;

  localparam logic [3:0] MIN_PRE = 4'(MIN_PRE_NIB);

  state_t      state;
  logic [3:0]  pre_cnt;
  logic [3:0]  low_nib;
  logic        frame_flag;
  logic        start_pending;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        start_frm;
  logic        end_frm;
  logic [15:0] byte_cnt;
  logic        length_error;
  logic        dribble;
  logic        err_seen;
  logic        crc_error;
  logic        sfd_ok;
  logic        trunc;

  assign sfd_ok = (bus.MRxD == 4'hD) && (pre_cnt >= MIN_PRE);
  assign trunc  = !bus.HugEn && (byte_cnt >= bus.MaxFL);

  // Main deframing FSM; strobes default low and are raised for a single cycle.
  always_ff @(posedge MRxClk or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      pre_cnt       <= 4'd0;
      low_nib       <= 4'd0;
      frame_flag    <= 1'b0;
      start_pending <= 1'b0;
      rx_data       <= 8'd0;
      rx_valid      <= 1'b0;
      start_frm     <= 1'b0;
      end_frm       <= 1'b0;
      byte_cnt      <= 16'd0;
      length_error  <= 1'b0;
      dribble       <= 1'b0;
      err_seen      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      start_frm <= 1'b0;
      end_frm   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.MRxDV) begin
            if (bus.MRxD == 4'h5) begin
              state   <= PREAMBLE;
              pre_cnt <= 4'd1;
            end else begin
              state      <= DROP;
              frame_flag <= 1'b0;
            end
          end
        end
        PREAMBLE: begin
          if (!bus.MRxDV) begin
            state <= IDLE;
          end else if (bus.MRxD == 4'h5) begin
            if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
          end else if (sfd_ok) begin
            state         <= DATA_LO;
            byte_cnt      <= 16'd0;
            length_error  <= 1'b0;
            dribble       <= 1'b0;
            err_seen      <= 1'b0;
            start_pending <= 1'b1;
          end else begin
            state      <= DROP;
            frame_flag <= 1'b0;
          end
        end
        DATA_LO: begin
          if (bus.MRxDV) begin
            low_nib <= bus.MRxD;
            if (bus.MRxErr) err_seen <= 1'b1;
            state <= DATA_HI;
          end else begin
            end_frm      <= 1'b1;
            length_error <= length_error | (byte_cnt < bus.MinFL);
            state        <= IDLE;
          end
        end
        DATA_HI: begin
          if (bus.MRxDV) begin
            if (bus.MRxErr) err_seen <= 1'b1;
            // An over-length byte is swallowed and the rest of the frame discarded.
            if (trunc) begin
              length_error <= 1'b1;
              frame_flag   <= 1'b1;
              state        <= DROP;
            end else begin
              rx_data       <= {bus.MRxD, low_nib};
              rx_valid      <= 1'b1;
              start_frm     <= start_pending;
              start_pending <= 1'b0;
              if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
              state <= DATA_LO;
            end
          end else begin
            end_frm      <= 1'b1;
            dribble      <= 1'b1;
            length_error <= length_error | (byte_cnt < bus.MinFL);
            state        <= IDLE;
          end
        end
        DROP: begin
          if (!bus.MRxDV) begin
            end_frm    <= frame_flag;
            frame_flag <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_RX_CRC_CHECK_EN
  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  logic [31:0] crc;

  // CRC advances a whole byte at a time so a trailing dribble nibble never enters it.
  always_ff @(posedge MRxClk or negedge Reset) begin
    if (!Reset) begin
      crc       <= 32'hFFFFFFFF;
      crc_error <= 1'b0;
    end else begin
      case (state)
        PREAMBLE: begin
          if (bus.MRxDV && sfd_ok) begin
            crc       <= 32'hFFFFFFFF;
            crc_error <= 1'b0;
          end
        end
        DATA_LO: begin
          if (!bus.MRxDV) crc_error <= (crc != CRC_RESIDUE);
        end
        DATA_HI: begin
          if (bus.MRxDV) begin
            if (!trunc) crc <= crc_nibble(crc_nibble(crc, low_nib), bus.MRxD);
          end else begin
            crc_error <= (crc != CRC_RESIDUE);
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign crc_error = 1'b0;
`endif

  assign bus.RxData        = rx_data;
  assign bus.RxValid       = rx_valid;
  assign bus.RxStartFrm    = start_frm;
  assign bus.RxEndFrm      = end_frm;
  assign bus.ByteCnt       = byte_cnt;
  assign bus.CrcError      = crc_error;
  assign bus.LengthError   = length_error;
  assign bus.DribbleNibble = dribble;
  assign bus.RxErrSeen     = err_seen;
  assign bus.Busy          = (state != IDLE);

endmodule

// File: tb/tb_eth_rxmii_deframer.sv
// Self-checking bench for eth_rxmii_deframer: table-driven frames, randomized frames
// against a frame-level reference model, and a hand-written mid-frame reset sequence.
module tb_eth_rxmii_deframer;

  localparam int MIN_PRE = 2;
`ifdef ETH_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef struct {
    int pre_len; logic [3:0] sfd; int len; int corrupt; bit extra; int err_byte;
    int minfl; int maxfl; bit hug;
    int exp_count; bit exp_end; int exp_cnt; bit exp_le; bit exp_dr; bit exp_crc; bit exp_err; bit chk_crc;
  } vec_t;

  logic MRxClk = 1'b0;
  logic Reset;
  eth_rxmii_deframer_if bus();

  eth_rxmii_deframer #(.MIN_PRE_NIB(MIN_PRE), .CRC_RESIDUE(32'hC704DD7B)) dut (
    .MRxClk(MRxClk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 MRxClk = ~MRxClk;

  int n_compared = 0;
  int n_mismatched = 0;
  logic [7:0] frame_q[$];
  logic [7:0] got_q[$];
  int start_seen, start_bad, end_cnt;

  // Collects delivered bytes and framing strobes away from the active edge.
  always @(negedge MRxClk) begin
    if (bus.RxValid) got_q.push_back(bus.RxData);
    if (bus.RxStartFrm) begin
      start_seen++;
      if (!bus.RxValid || got_q.size() != 1) start_bad++;
    end else if (bus.RxValid && got_q.size() == 1) begin
      start_bad++;
    end
    if (bus.RxEndFrm) end_cnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outVec();
    return {bus.RxData, bus.RxValid, bus.RxStartFrm, bus.RxEndFrm, bus.ByteCnt,
            bus.CrcError, bus.LengthError, bus.DribbleNibble, bus.RxErrSeen, bus.Busy};
  endfunction

  // Standard Ethernet CRC-32 over the first n bytes of frame_q, final value as transmitted.
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frame_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcsOk(input int n);
    return crc32(n - 4) == {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
  endfunction

  task automatic buildFrame(input vec_t v);
    logic [31:0] c;
    frame_q.delete();
    for (int i = 0; i < v.len - 4; i++) frame_q.push_back(8'($urandom));
    c = crc32(v.len - 4);
    frame_q.push_back(c[7:0]);
    frame_q.push_back(c[15:8]);
    frame_q.push_back(c[23:16]);
    frame_q.push_back(c[31:24]);
    if (v.corrupt >= 0) frame_q[v.corrupt] = frame_q[v.corrupt] ^ 8'h01;
  endtask

  // Frame-level expectations derived from the frame contents and limits.
  function automatic vec_t refModel(input vec_t v);
    vec_t r;
    r = v;
    r.exp_count = 0; r.exp_end = 0; r.exp_cnt = 0; r.exp_le = 0;
    r.exp_dr = 0; r.exp_crc = 0; r.exp_err = 0; r.chk_crc = 0;
    if (v.pre_len >= MIN_PRE && v.sfd == 4'hD) begin
      r.exp_end = 1;
      r.exp_err = (v.err_byte >= 0);
      if (!v.hug && v.len > v.maxfl) begin
        r.exp_count = v.maxfl; r.exp_cnt = v.maxfl; r.exp_le = 1;
      end else begin
        r.exp_count = v.len; r.exp_cnt = v.len; r.exp_le = (v.len < v.minfl);
        r.exp_dr = v.extra; r.exp_crc = CRC_ON && !fcsOk(v.len); r.chk_crc = 1;
      end
    end
    return r;
  endfunction

  task automatic driveNibble(input logic [3:0] nib, input logic err);
    bus.MRxDV = 1'b1; bus.MRxD = nib; bus.MRxErr = err;
    @(negedge MRxClk); #1;
  endtask

  task automatic driveFrame(input vec_t v, input int stop_byte);
    for (int p = 0; p < v.pre_len; p++) driveNibble(4'h5, 1'b0);
    driveNibble(v.sfd, 1'b0);
    for (int i = 0; i < v.len; i++) begin
      if (i == stop_byte) return;
      driveNibble(frame_q[i][3:0], i == v.err_byte);
      driveNibble(frame_q[i][7:4], i == v.err_byte);
    end
    if (v.extra) driveNibble(4'($urandom), 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int bad;
    bus.MinFL = 16'(v.minfl); bus.MaxFL = 16'(v.maxfl); bus.HugEn = v.hug;
    got_q.delete(); start_seen = 0; start_bad = 0; end_cnt = 0;
    driveFrame(v, -1);
    bus.MRxDV = 1'b0; bus.MRxErr = 1'b0;
    @(negedge MRxClk); #1;
    bad = 0;
    for (int i = 0; i < got_q.size() && i < v.exp_count; i++) if (got_q[i] !== frame_q[i]) bad++;
    checkOutput("rxvalid_count", got_q.size(), v.exp_count);
    checkOutput("rx_bytes", bad, 0);
    checkOutput("start_frm_align", start_bad, 0);
    checkOutput("start_frm_count", start_seen, (v.exp_count > 0) ? 1 : 0);
    checkOutput("end_frm_timing", bus.RxEndFrm, v.exp_end);
    checkOutput("end_frm_count", end_cnt, v.exp_end);
    checkOutput("busy_idle", bus.Busy, 0);
    if (v.exp_end) begin
      checkOutput("byte_cnt", bus.ByteCnt, v.exp_cnt);
      checkOutput("length_error", bus.LengthError, v.exp_le);
      checkOutput("dribble", bus.DribbleNibble, v.exp_dr);
      checkOutput("rx_err_seen", bus.RxErrSeen, v.exp_err);
      if (v.chk_crc) checkOutput("crc_error", bus.CrcError, v.exp_crc);
    end
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    // pre sfd len corrupt extra err min max hug | count end cnt le dr crc err chk
    tbl[0] = '{15, 4'hD,  64, -1, 1'b0, -1, 64, 1536, 1'b0,  64, 1'b1,  64, 1'b0, 1'b0, 1'b0,   1'b0, 1'b1};
    tbl[1] = '{15, 4'hD,  64, 10, 1'b0, -1, 64, 1536, 1'b0,  64, 1'b1,  64, 1'b0, 1'b0, CRC_ON, 1'b0, 1'b1};
    tbl[2] = '{15, 4'hD,  30, -1, 1'b0, -1, 64, 1536, 1'b0,  30, 1'b1,  30, 1'b1, 1'b0, 1'b0,   1'b0, 1'b1};
    tbl[3] = '{15, 4'hD,  30, -1, 1'b1, -1, 64, 1536, 1'b0,  30, 1'b1,  30, 1'b1, 1'b1, 1'b0,   1'b0, 1'b1};
    tbl[4] = '{15, 4'hD, 120, -1, 1'b0, -1, 64,  100, 1'b0, 100, 1'b1, 100, 1'b1, 1'b0, 1'b0,   1'b0, 1'b0};
    tbl[5] = '{15, 4'hD, 120, -1, 1'b0, -1, 64,  100, 1'b1, 120, 1'b1, 120, 1'b0, 1'b0, 1'b0,   1'b0, 1'b1};
    tbl[6] = '{ 2, 4'h7,  40, -1, 1'b0, -1, 64, 1536, 1'b0,   0, 1'b0,   0, 1'b0, 1'b0, 1'b0,   1'b0, 1'b0};
    tbl[7] = '{ 1, 4'hD,  40, -1, 1'b0, -1, 64, 1536, 1'b0,   0, 1'b0,   0, 1'b0, 1'b0, 1'b0,   1'b0, 1'b0};
    tbl[8] = '{15, 4'hD,  64, -1, 1'b0, 20, 64, 1536, 1'b0,  64, 1'b1,  64, 1'b0, 1'b0, 1'b0,   1'b1, 1'b1};
    tbl[9] = '{ 2, 4'hD,  64, -1, 1'b0, -1, 64, 1536, 1'b0,  64, 1'b1,  64, 1'b0, 1'b0, 1'b0,   1'b0, 1'b1};

    Reset = 1'b0;
    bus.MRxDV = 1'b0; bus.MRxD = 4'h0; bus.MRxErr = 1'b0;
    bus.MinFL = 16'd64; bus.MaxFL = 16'd1536; bus.HugEn = 1'b0;
    repeat (3) @(negedge MRxClk);
    #1;
    checkOutput("reset_state", outVec(), 32'd0);
    Reset = 1'b1;
    @(negedge MRxClk); #1;

    $display("[TB] table-driven frames");
    for (int t = 0; t < 10; t++) begin
      buildFrame(tbl[t]);
      applyStimulus(tbl[t]);
    end

    $display("[TB] randomized frames");
    for (int t = 0; t < 25; t++) begin
      int limit;
      rv = tbl[0];
      rv.pre_len = $urandom_range(0, 15);
      rv.sfd     = ($urandom_range(0, 5) == 0) ? 4'h7 : 4'hD;
      rv.len     = $urandom_range(5, 80);
      rv.minfl   = $urandom_range(0, 80);
      rv.maxfl   = $urandom_range(20, 100);
      rv.hug     = 1'($urandom_range(0, 1));
      rv.extra   = 1'($urandom_range(0, 1));
      rv.corrupt = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rv.len - 1) : -1;
      limit      = (rv.hug || rv.len <= rv.maxfl) ? rv.len : rv.maxfl;
      rv.err_byte = ($urandom_range(0, 3) == 0) ? $urandom_range(0, limit - 1) : -1;
      buildFrame(rv);
      rv = refModel(rv);
      applyStimulus(rv);
    end

    $display("[TB] reset in the middle of a frame");
    bus.MinFL = 16'd64; bus.MaxFL = 16'd1536; bus.HugEn = 1'b0;
    buildFrame(tbl[0]);
    driveFrame(tbl[0], 30);
    end_cnt = 0;
    Reset = 1'b0;
    #1;
    checkOutput("reset_mid_frame", outVec(), 32'd0);
    bus.MRxD = 4'hA;
    repeat (3) @(negedge MRxClk);
    #1;
    Reset = 1'b1;
    got_q.delete();
    @(negedge MRxClk); #1;
    checkOutput("drop_after_reset_busy", bus.Busy, 1);
    repeat (3) @(negedge MRxClk);
    #1;
    bus.MRxDV = 1'b0;
    repeat (2) @(negedge MRxClk);
    #1;
    checkOutput("no_end_after_reset", end_cnt, 0);
    checkOutput("no_bytes_after_reset", got_q.size(), 0);
    buildFrame(tbl[0]);
    applyStimulus(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
